// File: rtl/clock_div_ctrl.sv
// Run-time programmable clock divider with req/ack ratio changes landing on period boundaries.
// Optional period counter output enabled by defining CLOCK_DIV_CTRL_PCNT_EN.
module clock_div_ctrl #(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             div_req,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div,
   output logic             clk_out,
   output logic             tick
`ifdef CLOCK_DIV_CTRL_PCNT_EN
   ,
   output logic [15:0]      period_cnt
`endif
);

   localparam logic [1:0]       ST_STOP = 2'd0;
   localparam logic [1:0]       ST_RUN  = 2'd1;
   localparam logic [1:0]       ST_PEND = 2'd2;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic [1:0]       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
   logic [CNT_W-1:0] cur_div_r, cur_div_s;
   logic [CNT_W-1:0] pend_div_r, pend_div_s;
   logic             clk_out_r, clk_out_s;
   logic             tick_r, tick_s;
   logic             ack_r, ack_s;
   logic             err_r, err_s;
   logic             req_s, val_ok_s, wrap_s;

   // Next-state, counter and ratio-update decode
   always_comb begin
      req_s      = div_req && (state_r != ST_PEND);
      val_ok_s   = |div_val[CNT_W-1:1];
      wrap_s     = (cnt_r == (cur_div_r - CNT_ONE));
      cnt_inc_s  = wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
      state_s    = state_r;
      cnt_s      = cnt_r;
      cur_div_s  = cur_div_r;
      pend_div_s = pend_div_r;
      ack_s      = 1'b0;
      err_s      = req_s && !val_ok_s;
      case (state_r)
         ST_STOP: begin
            cnt_s = CNT_ZERO;
            if (req_s && val_ok_s) begin
               cur_div_s = div_val;
               ack_s     = 1'b1;
            end else begin
               cur_div_s = cur_div_r;
            end
            if (en) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_RUN: begin
            if (!en) begin
               // Stopping with a valid request: nothing to wait for, apply directly
               state_s = ST_STOP;
               cnt_s   = CNT_ZERO;
               if (req_s && val_ok_s) begin
                  cur_div_s = div_val;
                  ack_s     = 1'b1;
               end else begin
                  cur_div_s = cur_div_r;
               end
            end else begin
               cnt_s = cnt_inc_s;
               if (req_s && val_ok_s) begin
                  pend_div_s = div_val;
                  state_s    = ST_PEND;
               end else begin
                  state_s    = ST_RUN;
               end
            end
         end
         ST_PEND: begin
            if (!en) begin
               cur_div_s = pend_div_r;
               ack_s     = 1'b1;
               state_s   = ST_STOP;
               cnt_s     = CNT_ZERO;
            end else if (wrap_s) begin
               cur_div_s = pend_div_r;
               ack_s     = 1'b1;
               state_s   = ST_RUN;
               cnt_s     = CNT_ZERO;
            end else begin
               cnt_s     = cnt_inc_s;
            end
         end
         default: begin
            state_s = ST_STOP;
            cnt_s   = CNT_ZERO;
         end
      endcase
      if (state_s != ST_STOP) begin
         clk_out_s = (cnt_s < (cur_div_s >> 1));
         tick_s    = (cnt_s == CNT_ZERO);
      end else begin
         clk_out_s = 1'b0;
         tick_s    = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_r    <= ST_STOP;
         cnt_r      <= CNT_ZERO;
         cur_div_r  <= DIV_RST;
         pend_div_r <= CNT_ZERO;
         clk_out_r  <= 1'b0;
         tick_r     <= 1'b0;
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         cur_div_r  <= cur_div_s;
         pend_div_r <= pend_div_s;
         clk_out_r  <= clk_out_s;
         tick_r     <= tick_s;
         ack_r      <= ack_s;
         err_r      <= err_s;
      end
   end

   assign div_ack = ack_r;
   assign div_err = err_r;
   assign busy    = (state_r == ST_PEND);
   assign cur_div = cur_div_r;
   assign clk_out = clk_out_r;
   assign tick    = tick_r;

`ifdef CLOCK_DIV_CTRL_PCNT_EN
   logic [15:0] pcnt_r;

   // Periods since the last ratio change; an ack restarts the count
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         pcnt_r <= 16'd0;
      end else if (ack_s) begin
         pcnt_r <= 16'd0;
      end else if (tick_s) begin
         pcnt_r <= pcnt_r + 16'd1;
      end else begin
         pcnt_r <= pcnt_r;
      end
   end

   assign period_cnt = pcnt_r;
`endif

endmodule
